// File: rtl/pdm_pcm_capture.sv
// pdm_pcm_capture: drives a PDM microphone clock, samples the 1-bit stream on
// the falling edge of that clock, decimates it with a boxcar ones-counter into
// signed 16-bit PCM words, and flags words that are replaced before the
// serialiser has taken them.
//
// Optional feature: define PDM_DCBLOCK_EN to insert a first-order DC blocker
// after saturation (same register stage, so word latency is unchanged).
//
// Handshake: pcm_valid is a one-cycle pulse marking a new pcm_out; pcm_out is
// stable from that pulse until the next one. done is a one-cycle pulse from the
// consumer meaning "the word currently held has been loaded"; a done while no
// word is pending is ignored. A pcm_valid while a word is still pending sets
// the sticky overrun flag, unless done arrives in that same cycle.
//
// state_dbg exposes the capture state (0 = IDLE, 1 = SETTLE, 2 = RUN).
module pdm_pcm_capture #(
    parameter int CLK_DIV    = 25,
    parameter int DECIM      = 64,
    parameter int SHIFT      = 9,
    parameter int SETTLE_WIN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pdm_data,
    input  logic        done,
    output logic        pdm_clk,
    output logic [15:0] pcm_out,
    output logic        pcm_valid,
    output logic        overrun,
    output logic [1:0]  state_dbg
);

    localparam int                 DIV_W       = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]         BIT_LAST    = 8'(DECIM - 1);
    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_WIN - 1);
    localparam logic signed [23:0] HALF        = 24'(DECIM / 2);
    localparam logic signed [23:0] SAT_MAX     = 24'sd32767;
    localparam logic signed [23:0] SAT_MIN     = -24'sd32768;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t             state_q;
    logic               sync1_q, sync2_q;
    logic [DIV_W-1:0]   div_q;
    logic               pdm_clk_q;
    logic [7:0]         bit_cnt_q;
    logic [7:0]         ones_q;
    logic [7:0]         disc_q;
    logic [15:0]        pcm_q;
    logic               valid_q;
    logic               pending_q;
    logic               overrun_q;

    logic               div_term;
    logic               capture;
    logic               win_close;
    logic               word_fire;
    logic signed [23:0] centred;
    logic signed [23:0] scaled;
    logic [15:0]        sat_word;
    logic [15:0]        out_word;

`ifdef PDM_DCBLOCK_EN
    logic [15:0]        xprev_q, yprev_q;
    logic               enter_run;
    logic signed [19:0] x20, xp20, yp20, dc_y;
    logic [15:0]        dc_word;
`endif

    // Window arithmetic: the ones count already holds DECIM bits at close
    // (the carried-in bit plus DECIM-1 new ones), centre it, scale, saturate.
    always_comb begin
        div_term  = (state_q != IDLE) && (div_q == DIV_LAST);
        capture   = div_term && pdm_clk_q;
        win_close = capture && (bit_cnt_q == BIT_LAST);
        word_fire = enable && (state_q == RUN) && win_close;
        centred   = $signed({16'd0, ones_q}) - HALF;
        scaled    = centred <<< SHIFT;
        if (scaled > SAT_MAX) begin
            sat_word = 16'h7FFF;
        end else if (scaled < SAT_MIN) begin
            sat_word = 16'h8000;
        end else begin
            sat_word = scaled[15:0];
        end
`ifdef PDM_DCBLOCK_EN
        enter_run = enable &&
                    (((state_q == IDLE) && (SETTLE_WIN == 0)) ||
                     ((state_q == SETTLE) && win_close && (disc_q == SETTLE_LAST)));
        x20  = {{4{sat_word[15]}}, sat_word};
        xp20 = {{4{xprev_q[15]}}, xprev_q};
        yp20 = {{4{yprev_q[15]}}, yprev_q};
        dc_y = x20 - xp20 + yp20 - (yp20 >>> 8);
        if (dc_y > 20'sd32767) begin
            dc_word = 16'h7FFF;
        end else if (dc_y < -20'sd32768) begin
            dc_word = 16'h8000;
        end else begin
            dc_word = dc_y[15:0];
        end
        out_word = dc_word;
`else
        out_word = sat_word;
`endif
    end

    // Two-flop synchroniser for the asynchronous microphone data.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pdm_data;
            sync2_q <= sync1_q;
        end
    end

    // Capture FSM: clock divider, bit/ones counters and settle-window discard.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state_q   <= IDLE;
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            disc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_q     <= '0;
                    pdm_clk_q <= 1'b0;
                    bit_cnt_q <= '0;
                    ones_q    <= '0;
                    disc_q    <= '0;
                    state_q   <= (SETTLE_WIN == 0) ? RUN : SETTLE;
                end
                default: begin
                    if (div_term) begin
                        div_q     <= '0;
                        pdm_clk_q <= ~pdm_clk_q;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                    if (capture) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            ones_q    <= {7'd0, sync2_q};
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                            ones_q    <= ones_q + {7'd0, sync2_q};
                        end
                    end
                    if (win_close && (state_q == SETTLE)) begin
                        disc_q <= disc_q + 8'd1;
                        if (disc_q == SETTLE_LAST) begin
                            state_q <= RUN;
                        end
                    end
                end
            endcase
        end
    end

    // Word register: pcm_out/pcm_valid update the cycle after a RUN window close.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcm_q   <= '0;
            valid_q <= 1'b0;
`ifdef PDM_DCBLOCK_EN
            xprev_q <= '0;
            yprev_q <= '0;
`endif
        end else begin
            valid_q <= word_fire;
            if (word_fire) begin
                pcm_q <= out_word;
            end
`ifdef PDM_DCBLOCK_EN
            if (enter_run) begin
                xprev_q <= '0;
                yprev_q <= '0;
            end else if (word_fire) begin
                xprev_q <= sat_word;
                yprev_q <= dc_word;
            end
`endif
        end
    end

    // Consumption tracking: pending follows valid/done, overrun is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (valid_q) begin
            if (pending_q && !done) begin
                overrun_q <= 1'b1;
            end
            pending_q <= 1'b1;
        end else if (done) begin
            pending_q <= 1'b0;
        end
    end

    assign pdm_clk   = pdm_clk_q;
    assign pcm_out   = pcm_q;
    assign pcm_valid = valid_q;
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pdm_pcm_capture.sv
// Bench for pdm_pcm_capture: three instances (fast divider, SHIFT=10 for
// saturation, default parameters for real timing) share the stimulus.
`timescale 1ns/1ps
module tb_pdm_pcm_capture;

    localparam int DECIM = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset, enable, pdm_data, done;
    always #5 clk = ~clk;

    logic        f_pdm_clk, f_valid, f_ovr;
    logic [15:0] f_pcm;
    logic [1:0]  f_state;
    logic        s_pdm_clk, s_valid, s_ovr;
    logic [15:0] s_pcm;
    logic [1:0]  s_state;
    logic        w_pdm_clk, w_valid, w_ovr;
    logic [15:0] w_pcm;
    logic [1:0]  w_state;

    pdm_pcm_capture #(.CLK_DIV(2), .DECIM(64), .SHIFT(9), .SETTLE_WIN(2)) u_fast (
        .clk(clk), .reset(reset), .enable(enable), .pdm_data(pdm_data), .done(done),
        .pdm_clk(f_pdm_clk), .pcm_out(f_pcm), .pcm_valid(f_valid), .overrun(f_ovr),
        .state_dbg(f_state)
    );

    pdm_pcm_capture #(.CLK_DIV(2), .DECIM(64), .SHIFT(10), .SETTLE_WIN(2)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .pdm_data(pdm_data), .done(done),
        .pdm_clk(s_pdm_clk), .pcm_out(s_pcm), .pcm_valid(s_valid), .overrun(s_ovr),
        .state_dbg(s_state)
    );

    pdm_pcm_capture u_slow (
        .clk(clk), .reset(reset), .enable(enable), .pdm_data(pdm_data), .done(done),
        .pdm_clk(w_pdm_clk), .pcm_out(w_pcm), .pcm_valid(w_valid), .overrun(w_ovr),
        .state_dbg(w_state)
    );

    // ---------------- scoreboard / model state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_sat_q[$];
    int          bits[$];
    bit          pending_m, overrun_m;
    int          xp_f, yp_f, xp_s, yp_s;
    logic [15:0] last_f, last_s;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int window_word(input int cnt, input int shift);
        return sat16((cnt - DECIM / 2) * (1 << shift));
    endfunction

    function automatic logic next_bit(input int mode, input int idx, input int pct);
        case (mode)
            0: return 1'b1;
            1: return 1'b0;
            2: return (idx % 2) == 0;
            default: return $urandom_range(0, 99) < pct;
        endcase
    endfunction

    // Reference: one decimated word per full window of DECIM captured bits.
    task automatic model_word(input int cnt);
        int xf, xs;
`ifdef PDM_DCBLOCK_EN
        int yf, ys;
`endif
        xf = window_word(cnt, 9);
        xs = window_word(cnt, 10);
`ifdef PDM_DCBLOCK_EN
        yf = sat16(xf - xp_f + yp_f - (yp_f >>> 8));
        ys = sat16(xs - xp_s + yp_s - (yp_s >>> 8));
        xp_f = xf; yp_f = yf; xf = yf;
        xp_s = xs; yp_s = ys; xs = ys;
`endif
        exp_q.push_back(16'(xf));
        exp_sat_q.push_back(16'(xs));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0; done = 1'b0; reset = 1'b1;
        step(); step();
        reset = 1'b0;
        pending_m = 1'b0; overrun_m = 1'b0;
        last_f = '0; last_s = '0;
        exp_q.delete(); exp_sat_q.delete();
    endtask

    // Enable from IDLE, feed one bit per pdm_clk period (changed just after the
    // falling edge), check every cycle's pcm_valid and each word, then disable.
    // done_mode: 0 never, 1 the cycle after pcm_valid, 2 coincident with pcm_valid.
    task automatic run_capture(input int mode, input int pct, input int done_mode,
                               input int n_cap, input bit drop_high);
        int caps, cycles, cnt;
        bit prev_clk, valid_prev, exp_valid, done_now;
        logic [15:0] e, es;
        bits.delete();
        caps = 0; cycles = 0; prev_clk = 1'b0; valid_prev = 1'b0;
        xp_f = 0; yp_f = 0; xp_s = 0; yp_s = 0;
        pdm_data = next_bit(mode, 0, pct);
        enable = 1'b1;
        while (caps < n_cap && cycles < n_cap * 8 + 100) begin
            step();
            cycles++;
            exp_valid = 1'b0;
            if (prev_clk && !f_pdm_clk) begin
                bits.push_back(int'(pdm_data));
                if ((caps % DECIM) == DECIM - 1 && (caps / DECIM) >= 2) begin
                    cnt = 0;
                    for (int i = caps - DECIM; i < caps; i++) cnt += bits[i];
                    model_word(cnt);
                    exp_valid = 1'b1;
                end
                caps++;
                pdm_data = next_bit(mode, caps, pct);
            end
            prev_clk = f_pdm_clk;
            done_now = (done_mode == 2) ? f_valid : (done_mode == 1) ? valid_prev : 1'b0;
            done = done_now;
            checks++;
            if (f_valid !== exp_valid)
                $display("FAIL valid_timing cap=%0d: got %b expected %b", caps, f_valid, exp_valid);
            checks++;
            if (s_valid !== exp_valid)
                $display("FAIL sat_valid_timing cap=%0d: got %b expected %b", caps, s_valid, exp_valid);
            if (f_valid !== exp_valid) failures++;
            if (s_valid !== exp_valid) failures++;
            if (f_valid === 1'b1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    es = exp_sat_q.pop_front();
                    last_f = e; last_s = es;
                    checks++;
                    if (f_pcm !== e) begin
                        failures++;
                        $display("FAIL pcm_word: got %0d expected %0d", $signed(f_pcm), $signed(e));
                    end
                    checks++;
                    if (s_pcm !== es) begin
                        failures++;
                        $display("FAIL sat_word: got %0d expected %0d", $signed(s_pcm), $signed(es));
                    end
                end
                checks++;
                if (f_ovr !== overrun_m) begin
                    failures++;
                    $display("FAIL overrun_at_valid: got %b expected %b", f_ovr, overrun_m);
                end
                if (pending_m && !done_now) overrun_m = 1'b1;
                pending_m = 1'b1;
            end else if (done_now) begin
                pending_m = 1'b0;
            end
            valid_prev = f_valid;
        end
        checks++;
        if (caps < n_cap) begin
            failures++;
            $display("FAIL capture_timeout: got %0d captures expected %0d", caps, n_cap);
        end
        done = 1'b0;
        if (drop_high) begin
            for (int i = 0; i < 8 && f_pdm_clk !== 1'b1; i++) step();
            checks++;
            if (f_pdm_clk !== 1'b1) begin
                failures++;
                $display("FAIL drop_setup_pdm_clk: got %b expected 1", f_pdm_clk);
            end
        end
        enable = 1'b0;
        step();
        checks++;
        if (f_pdm_clk !== 1'b0) begin
            failures++;
            $display("FAIL idle_pdm_clk: got %b expected 0", f_pdm_clk);
        end
        checks++;
        if (f_state !== 2'd0) begin
            failures++;
            $display("FAIL idle_state: got %0d expected 0", f_state);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (f_valid !== 1'b0 || f_pcm !== last_f || f_pdm_clk !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold: valid=%b pcm=%0h pdm_clk=%b expected 0 %0h 0",
                         f_valid, f_pcm, f_pdm_clk, last_f);
            end
            step();
        end
        checks++;
        if (f_ovr !== overrun_m) begin
            failures++;
            $display("FAIL overrun_after_run: got %b expected %b", f_ovr, overrun_m);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL words_missing: got %0d left expected 0", exp_q.size());
        end
        exp_q.delete(); exp_sat_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({f_pdm_clk, f_valid, f_ovr, f_state, f_pcm} !== 21'd0) begin
            failures++;
            $display("FAIL reset_fast: got pdm_clk=%b valid=%b ovr=%b state=%0d pcm=%0h expected all 0",
                     f_pdm_clk, f_valid, f_ovr, f_state, f_pcm);
        end
        checks++;
        if ({s_pcm, s_valid, w_pdm_clk, w_pcm} !== 34'd0) begin
            failures++;
            $display("FAIL reset_others: got sat_pcm=%0h slow_pdm_clk=%b slow_pcm=%0h expected 0",
                     s_pcm, w_pdm_clk, w_pcm);
        end
    endtask

    // Default parameters: pdm_clk period 50, first word after 3 windows, 3200 apart.
    task automatic test_slow_timing();
        int rise[$];
        int vld[$];
        bit prev_c, prev_v;
        do_reset();
        pdm_data = 1'b1;
        enable = 1'b1;
        prev_c = 1'b0; prev_v = 1'b0;
        for (int n = 1; n <= 16005; n++) begin
            step();
            if (!prev_c && w_pdm_clk) rise.push_back(n);
            prev_c = w_pdm_clk;
            done = prev_v;
            if (w_valid === 1'b1) begin
                vld.push_back(n);
                checks++;
                if (w_pcm !== 16'h4000) begin
                    failures++;
                    $display("FAIL slow_word: got %0h expected 4000", w_pcm);
                end
            end
            prev_v = w_valid;
        end
        done = 1'b0;
        checks++;
        if (rise.size() < 2 || rise[0] != 26 || rise[1] != 76) begin
            failures++;
            $display("FAIL slow_pdm_clk_rise: got %0d,%0d expected 26,76",
                     rise.size() > 0 ? rise[0] : -1, rise.size() > 1 ? rise[1] : -1);
        end
        checks++;
        if (vld.size() != 3 || vld[0] != 9601 || vld[1] != 12801 || vld[2] != 16001) begin
            failures++;
            $display("FAIL slow_valid_times: got n=%0d first=%0d expected 3 at 9601,12801,16001",
                     vld.size(), vld.size() > 0 ? vld[0] : -1);
        end
        checks++;
        if (w_ovr !== 1'b0) begin
            failures++;
            $display("FAIL slow_overrun: got %b expected 0", w_ovr);
        end
    endtask

    task automatic test_patterns();
        do_reset();
        run_capture(0, 0, 1, DECIM * 5 + 1, 1'b0);                   // all ones
        run_capture(1, 0, 1, DECIM * 5 + 1, 1'b0);                   // all zeros
        run_capture(2, 0, 1, DECIM * 5 + 1, 1'b0);                   // alternating
        run_capture(3, 50, 1, DECIM * 5 + 1, 1'b0);                  // random
        run_capture(3, $urandom_range(5, 95), 1, DECIM * 5 + 1, 1'b0); // biased random
        checks++;
        if (f_ovr !== 1'b0) begin
            failures++;
            $display("FAIL patterns_overrun: got %b expected 0", f_ovr);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        run_capture(3, 50, 0, DECIM * 5 + 1, 1'b0);
        checks++;
        if (f_ovr !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got %b expected 1", f_ovr);
        end
        do_reset();
        checks++;
        if (f_ovr !== 1'b0) begin
            failures++;
            $display("FAIL overrun_reset: got %b expected 0", f_ovr);
        end
    endtask

    task automatic test_back_to_back_done();
        do_reset();
        run_capture(3, 30, 2, DECIM * 6 + 1, 1'b0);
        checks++;
        if (f_ovr !== 1'b0) begin
            failures++;
            $display("FAIL coincident_done: got %b expected 0", f_ovr);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        run_capture(3, 70, 1, DECIM * 3 + 30, 1'b1);
        run_capture(0, 0, 1, DECIM * 4 + 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int nv;
        do_reset();
        nv = 0;
        enable = 1'b1;
        for (int n = 1; n <= 1200; n++) begin
            pdm_data = 1'($urandom_range(0, 1));
            step();
            if (f_valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 2 || f_ovr !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state: got words=%0d ovr=%b expected 2 1", nv, f_ovr);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({f_pdm_clk, f_valid, f_ovr, f_state, f_pcm} !== 21'd0) begin
            failures++;
            $display("FAIL reset_mid_window: got pdm_clk=%b valid=%b ovr=%b state=%0d pcm=%0h expected all 0",
                     f_pdm_clk, f_valid, f_ovr, f_state, f_pcm);
        end
        do_reset();
        run_capture(3, 40, 1, DECIM * 4 + 1, 1'b0);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        reset = 1'b1; enable = 1'b0; pdm_data = 1'b0; done = 1'b0;
        test_reset();
        test_slow_timing();
        test_patterns();
        test_overrun();
        test_back_to_back_done();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdm_pcm_capture.md
Name: pdm_pcm_capture

Overview:
- Upstream stage of the PCM audio path: drives a PDM microphone clock and samples the microphone's 1-bit stream.
- Decimates the stream with a boxcar ones-counter into signed 16-bit PCM words.
- Holds each word on a parallel output that feeds the serialiser's 16-bit d_in.
- Tracks the serialiser's done pulse and flags any word overwritten before it was consumed.

Parameters:
- CLK_DIV, 25: clk cycles per pdm_clk half-period (50 MHz gives a 1 MHz pdm_clk); legal values are 2 or more.
- DECIM, 64: PDM bits per PCM word; must be even and 2..255.
- SHIFT, 9: left shift applied to the centred ones-count.
- SETTLE_WIN, 2: number of full windows discarded after enable rises.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  capture enable
- pdm_data  in  1  microphone data, asynchronous to clk
- done  in  1  one-cycle pulse from the serialiser when it has loaded the current word
- pdm_clk  out  1  microphone clock
- pcm_out  out  16  signed PCM word; connects to the serialiser's d_in
- pcm_valid  out  1  one-cycle pulse when pcm_out updates
- overrun  out  1  sticky: a word was replaced before done was seen

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: pdm_clk=0, pcm_out=0, pcm_valid=0, overrun=0, state=IDLE, all counters=0, sync flops=0.
- Reset asserted mid-window discards the partial count; capture restarts from IDLE.
- pdm_data passes through a 2-flop synchroniser before any use.
- pdm_clk generation:
  - Divider counts 0..CLK_DIV-1 only while state is not IDLE; pdm_clk toggles at the terminal count.
  - In IDLE: pdm_clk=0 and the divider is held at 0.
- Bit capture: the synchronised bit is captured in the clk cycle where pdm_clk toggles 1->0 (left/low-channel mic timing).
- Window counting:
  - bit_cnt counts captured bits 0..DECIM-1 and wraps.
  - ones_cnt (8 bits) accumulates captured 1s over the window.
- Window close, in the cycle the DECIM-th bit is captured:
  - word = (ones_cnt_final - DECIM/2) <<< SHIFT, computed signed in 24 bits.
  - Saturate to [-32768, +32767].
  - ones_cnt reloads with the current bit (0 or 1), so no bit is lost.
- Word delivery latency: pcm_out and pcm_valid update one clk after window close. pcm_out holds its value until the next update.
- State machine:
  - IDLE: wait for enable=1 -> SETTLE, with discard counter=0.
  - SETTLE: count completed windows without asserting pcm_valid. When the count reaches SETTLE_WIN -> RUN. With SETTLE_WIN=0, go directly to RUN.
  - RUN: every window close produces a word.
  - From any state, enable=0 -> IDLE in the next cycle. Partial window dropped, counters cleared, pcm_out retains its last value, no pcm_valid.
- Consumption tracking:
  - A pending flag sets with pcm_valid and clears on done.
  - If pcm_valid fires while pending=1, overrun sets and stays set until reset.
  - done and pcm_valid in the same cycle: the done clears the previous word, so no overrun; pending then remains 1 for the new word.
  - done with pending=0 is ignored.

Optional Feature:
- Macro: PDM_DCBLOCK_EN.
- When defined: a first-order DC blocker follows saturation.
  - y = x - x_prev + y_prev - (y_prev >>> 8), computed in 20-bit signed arithmetic, then saturated to 16 bits.
  - x_prev and y_prev reset to 0, and reset to 0 again on entry to RUN.
  - pcm_out carries y. Latency stays one clk after window close; the filter update is in the same register stage.
- When undefined: pcm_out carries the saturated word directly; no filter registers exist.

Test Plan:
- CLK_DIV=25, enable=1, pdm_data=1 constant -> pdm_clk period 50 clk. First pcm_valid after 3 windows (2 discarded) with pcm_out=+16384; every 3200 clk thereafter; overrun stays 0 when done is returned each word.
- pdm_data=0 constant -> pcm_out=-16384 (16'hC000). Alternating 1/0 per bit -> pcm_out=0.
- SHIFT=10, all ones -> raw +32768 saturates to +32767 (16'h7FFF).
- Two consecutive words without any done -> overrun=1 on the second pcm_valid and stays 1. Done coincident with pcm_valid -> overrun stays 0.
- enable dropped at bit 30 of a window -> next cycle pdm_clk=0, no pcm_valid, pcm_out unchanged. Re-enable -> 2 windows discarded again. Reset mid-window -> all outputs at reset values.
- PDM_DCBLOCK_EN defined, all ones -> first word +16384, then strictly decreasing magnitude toward 0 (second word 16320).
